// File: rtl/bpc_pkg.sv
// rtl/bpc_pkg.sv - shared constants and state type for the BPC flit packer
package bpc_pkg;
  localparam int FLIT_W    = 64;
  localparam int BUF_W     = 2 * FLIT_W;
  localparam int HDR_W     = 18;
  localparam int BASE_MSB  = 61;
  localparam int BASE_LSB  = 46;
  localparam int MAX_FLITS = 17;
  localparam int CW_LEN_W  = 7;
  localparam int FILL_W    = $clog2(BUF_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;
endpackage

// File: rtl/bpc_flit_packer_if.sv
// rtl/bpc_flit_packer_if.sv - codeword input and flit output link of the packer
interface bpc_flit_packer_if;
  import bpc_pkg::*;

  logic                cw_valid_i;
  logic [FLIT_W-1:0]   cw_data_i;
  logic [CW_LEN_W-1:0] cw_len_i;
  logic                cw_sop_i;
  logic                cw_eop_i;
  logic [15:0]         base_i;
  logic                ready_o;
  logic                valid_o;
  logic [FLIT_W-1:0]   data_o;
  logic                sop_o;
  logic                eop_o;
  logic                ready_i;
  logic                err_o;

  modport slave (
    input  cw_valid_i, cw_data_i, cw_len_i, cw_sop_i, cw_eop_i, base_i, ready_i,
    output ready_o, valid_o, data_o, sop_o, eop_o, err_o
  );

  modport master (
    output cw_valid_i, cw_data_i, cw_len_i, cw_sop_i, cw_eop_i, base_i, ready_i,
    input  ready_o, valid_o, data_o, sop_o, eop_o, err_o
  );
endinterface

// File: rtl/bpc_bit_aligner.sv
// rtl/bpc_bit_aligner.sv - places the valid MSB-aligned bits of a codeword at a bit offset
module bpc_bit_aligner
  import bpc_pkg::*;
(
  input  logic [FLIT_W-1:0]   cw_data,
  input  logic [CW_LEN_W-1:0] cw_len,
  input  logic [FILL_W-1:0]   offset,
  output logic [BUF_W-1:0]    aligned
);
  logic [FLIT_W-1:0] keep_mask;

  // Don't-care bits below the codeword length are cleared so they never leak into the pad.
  always_comb begin
    keep_mask = ~({FLIT_W{1'b1}} >> cw_len);
    aligned   = {cw_data & keep_mask, {FLIT_W{1'b0}}} >> offset;
  end
endmodule

// File: rtl/bpc_flit_packer.sv
// rtl/bpc_flit_packer.sv - packs variable-length BPC codewords into 64-bit flits
module bpc_flit_packer
  import bpc_pkg::*;
(
  input logic              clk,
  input logic              rst,
  bpc_flit_packer_if.slave bus
);
  localparam logic [FILL_W-1:0] FLIT_F = FILL_W'(FLIT_W);
  localparam logic [FILL_W-1:0] HDR_F  = FILL_W'(HDR_W);
  localparam logic [4:0]        CAP    = 5'(MAX_FLITS);

  state_e            state, m_state;
  logic [BUF_W-1:0]  buf_q, hdr, m_buf, aligned;
  logic [FILL_W-1:0] fill, m_fill, offset, fill_left;
  logic [4:0]        flit_cnt, cnt_base;
  logic              first_q, first_base;
  logic              take, sop_take, app, drop, can_load, emit, is_last, over_cap, eop_taken;

  assign bus.ready_o = (state == ST_IDLE) || (state == ST_FILL && fill <= FLIT_F);

  bpc_bit_aligner u_align (
    .cw_data (bus.cw_data_i),
    .cw_len  (bus.cw_len_i),
    .offset  (offset),
    .aligned (aligned)
  );

  // The incoming codeword is merged before the emit decision so a flit can leave the cycle after acceptance.
  always_comb begin
    take     = bus.cw_valid_i && bus.ready_o;
    sop_take = take && state == ST_IDLE && bus.cw_sop_i;
    drop     = take && state == ST_IDLE && !bus.cw_sop_i;
    app      = take && state == ST_FILL;
    hdr      = '0;
    hdr[BASE_MSB+FLIT_W -: BASE_MSB-BASE_LSB+1] = bus.base_i;
    offset     = (state == ST_IDLE) ? HDR_F : fill;
    m_buf      = buf_q;
    m_fill     = fill;
    m_state    = state;
    cnt_base   = flit_cnt;
    first_base = first_q;
    if (sop_take) begin
      m_buf      = hdr | aligned;
      m_fill     = HDR_F + FILL_W'(bus.cw_len_i);
      m_state    = bus.cw_eop_i ? ST_FLUSH : ST_FILL;
      cnt_base   = '0;
      first_base = 1'b1;
    end else if (app) begin
      m_buf  = buf_q | aligned;
      m_fill = fill + FILL_W'(bus.cw_len_i);
      if (bus.cw_eop_i) m_state = ST_FLUSH;
    end
    can_load  = !bus.valid_o || bus.ready_i;
    emit      = can_load && (m_fill >= FLIT_F || (m_state == ST_FLUSH && m_fill != '0));
    is_last   = m_state == ST_FLUSH && m_fill <= FLIT_F;
    over_cap  = emit && cnt_base == CAP;
    fill_left = (m_fill >= FLIT_F) ? m_fill - FLIT_F : '0;
    eop_taken = bus.valid_o && bus.ready_i && bus.eop_o && state == ST_FLUSH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      fill        <= '0;
      buf_q       <= '0;
      flit_cnt    <= '0;
      first_q     <= 1'b0;
      bus.valid_o <= 1'b0;
      bus.data_o  <= '0;
      bus.sop_o   <= 1'b0;
      bus.eop_o   <= 1'b0;
      bus.err_o   <= 1'b0;
    end else begin
      bus.err_o <= drop || (app && bus.cw_sop_i) || over_cap;
      first_q   <= first_base && !emit;
      if (emit) begin
        bus.valid_o <= 1'b1;
        bus.data_o  <= m_buf[BUF_W-1 -: FLIT_W];
        bus.sop_o   <= first_base;
        bus.eop_o   <= is_last || over_cap;
        flit_cnt    <= (cnt_base < CAP) ? cnt_base + 5'd1 : cnt_base;
        // A runaway block is cut at the forced eop; whatever is still buffered is dropped.
        if (over_cap && !is_last) begin
          buf_q <= '0;
          fill  <= '0;
          state <= ST_FLUSH;
        end else begin
          buf_q <= m_buf << FLIT_W;
          fill  <= fill_left;
          state <= m_state;
        end
      end else begin
        if (bus.ready_i) bus.valid_o <= 1'b0;
        flit_cnt <= cnt_base;
        buf_q    <= m_buf;
        fill     <= m_fill;
        state    <= eop_taken ? ST_IDLE : m_state;
      end
    end
  end
endmodule

// File: tb/tb_bpc_flit_packer.sv
// tb/tb_bpc_flit_packer.sv - randomized self-checking bench for bpc_flit_packer
module tb_bpc_flit_packer;
  import bpc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bpc_flit_packer_if bus ();

  bpc_flit_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] cw_d[$];
  int          cw_l[$];
  logic [63:0] exp_data[$];
  logic [1:0]  exp_flag[$];
  int          exp_nfl;
  int          t;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic new_block(input int n, input int fixed_len);
    cw_d.delete();
    cw_l.delete();
    for (int k = 0; k < n; k++) begin
      cw_d.push_back({$urandom, $urandom});
      cw_l.push_back(fixed_len > 0 ? fixed_len : int'($urandom_range(1, 64)));
    end
  endtask

  // Reference: a flat bitstream of header + code bits, cut into zero-padded 64-bit flits.
  task automatic build_expected(input logic [15:0] base);
    bit          q[$];
    logic [63:0] w;
    exp_data.delete();
    exp_flag.delete();
    q.push_back(1'b0);
    q.push_back(1'b0);
    for (int i = 15; i >= 0; i--) q.push_back(base[i]);
    for (int k = 0; k < cw_l.size(); k++)
      for (int b = 0; b < cw_l[k]; b++) q.push_back(cw_d[k][63-b]);
    exp_nfl = (q.size() + 63) / 64;
    for (int f = 0; f < exp_nfl; f++) begin
      w = '0;
      for (int b = 0; b < 64; b++)
        if (f * 64 + b < q.size()) w[63-b] = q[f*64+b];
      exp_data.push_back(w);
      exp_flag.push_back({f == 0, f == exp_nfl - 1});
    end
  endtask

  // mode 0: ready_i=1, 1: random ready_i and codeword gaps, 2: 5-cycle stall after 2 flits
  task automatic run_block(input logic [15:0] base, input int mode, input int stop_after, output int taken);
    int   n, idx, cyc, stall;
    logic r;
    bit   low_seen;
    n = cw_l.size();
    build_expected(base);
    idx = 0; taken = 0; cyc = 0; stall = 0; low_seen = 0;
    while ((idx < n || exp_data.size() > 0) && cyc < 3000 && !(stop_after > 0 && taken >= stop_after)) begin
      @(negedge clk);
      cyc++;
      case (mode)
        1: r = ($urandom_range(0, 3) != 0);
        2: if (taken >= 2 && stall < 5) begin r = 1'b0; stall++; end else r = 1'b1;
        default: r = 1'b1;
      endcase
      bus.ready_i = r;
      if (mode == 2 && !r && !bus.ready_o) low_seen = 1;
      check_val("err_quiet", 64'(bus.err_o), 64'(0));
      if (bus.valid_o) begin
        if (exp_data.size() == 0) check_val("extra_flit", 64'(1), 64'(0));
        else begin
          check_val("flit_data", bus.data_o, exp_data[0]);
          check_val("flit_sop_eop", 64'({bus.sop_o, bus.eop_o}), 64'(exp_flag[0]));
          if (r) begin
            void'(exp_data.pop_front());
            void'(exp_flag.pop_front());
            taken++;
          end
        end
      end
      if (idx < n && !(mode == 1 && $urandom_range(0, 3) == 0)) begin
        bus.cw_valid_i = 1'b1;
        bus.cw_data_i  = cw_d[idx];
        bus.cw_len_i   = 7'(cw_l[idx]);
        bus.cw_sop_i   = (idx == 0);
        bus.cw_eop_i   = (idx == n - 1);
        bus.base_i     = base;
        if (bus.ready_o) idx++;
      end else begin
        bus.cw_valid_i = 1'b0;
      end
    end
    if (stop_after == 0) check_val("block_done", 64'(idx == n && exp_data.size() == 0), 64'(1));
    if (mode == 2) check_val("ready_o_drop", 64'(low_seen), 64'(1));
  endtask

  initial begin
    rst            = 1'b1;
    bus.cw_valid_i = 1'b0;
    bus.cw_data_i  = '0;
    bus.cw_len_i   = '0;
    bus.cw_sop_i   = 1'b0;
    bus.cw_eop_i   = 1'b0;
    bus.base_i     = '0;
    bus.ready_i    = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_valid", 64'(bus.valid_o), 64'(0));
    check_val("rst_sop_eop_err", 64'({bus.sop_o, bus.eop_o, bus.err_o}), 64'(0));
    check_val("rst_data", bus.data_o, 64'(0));
    check_val("rst_ready", 64'(bus.ready_o), 64'(1));
    rst = 1'b0;

    new_block(16, 3);
    run_block(16'hABCD, 0, 0, t);
    check_val("len3_nflits", 64'(t), 64'(2));

    new_block(1, 46);
    run_block(16'($urandom), 0, 0, t);
    check_val("len46_nflits", 64'(t), 64'(1));

    new_block(16, 64);
    run_block(16'($urandom), 0, 0, t);
    check_val("len64_nflits", 64'(t), 64'(17));

    new_block(16, 64);
    run_block(16'($urandom), 2, 0, t);
    check_val("stall_nflits", 64'(t), 64'(17));

    @(negedge clk);
    bus.cw_valid_i = 1'b1;
    bus.cw_sop_i   = 1'b0;
    bus.cw_eop_i   = 1'b0;
    bus.cw_len_i   = 7'd5;
    @(negedge clk);
    bus.cw_valid_i = 1'b0;
    check_val("idle_nosop_err", 64'(bus.err_o), 64'(1));
    check_val("idle_nosop_valid", 64'(bus.valid_o), 64'(0));
    @(negedge clk);
    check_val("idle_nosop_err_clr", 64'(bus.err_o), 64'(0));
    check_val("idle_nosop_valid2", 64'(bus.valid_o), 64'(0));

    new_block(16, 64);
    run_block(16'($urandom), 0, 2, t);
    @(negedge clk);
    bus.cw_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_valid", 64'(bus.valid_o), 64'(0));
    check_val("midrst_ready", 64'(bus.ready_o), 64'(1));
    rst = 1'b0;
    new_block(5, 0);
    run_block(16'h1357, 0, 0, t);
    check_val("post_rst_nflits", 64'(t), 64'(exp_nfl));

    for (int b = 0; b < 25; b++) begin
      new_block(int'($urandom_range(1, 16)), 0);
      run_block(16'($urandom), int'($urandom_range(0, 1)), 0, t);
      check_val("rnd_nflits", 64'(t), 64'(exp_nfl));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
